if2_id_inst_buffer: RTL

- Instruction buffer between the IF2 predecoder and the ID stage.
- Queues predecoded fetch packets (IR, PC, predicted target, br_type) in a FIFO and decouples fetch from decode backpressure.
- Flushes on a backend redirect.
- Optionally issues an early front-end redirect for b/bl and discards wrong-path fetches until the target arrives.

---
 rtl/if2_id_inst_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if2_id_inst_buffer.sv
// IF2->ID instruction buffer: circular FIFO of predecoded fetch packets.
// Define IBUF_EARLY_REDIRECT_EN for early b/bl redirect with wrong-path skip.
module if2_id_inst_buffer #(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_IR,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_PC_pre,
  input  logic [1:0]  in_br_type,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_IR,
  output logic [31:0] out_PC,
  output logic [31:0] out_PC_pre,
  output logic [1:0]  out_br_type,
  input  logic        id_ready,
  output logic        pre_redirect,
  output logic [31:0] pre_target
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [31:0]       ir_q  [DEPTH];
  logic [31:0]       pc_q  [DEPTH];
  logic [31:0]       pre_q [DEPTH];
  logic [1:0]        bt_q  [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic drop;
  logic enq;
  logic deq;

  assign in_ready  = !rst && (count != FULL);
  assign out_valid = !rst && (count != '0);

  assign enq = in_valid && in_ready && !drop && !flush;
  assign deq = out_valid && id_ready && !flush;

  always_comb begin
    out_IR      = '0;
    out_PC      = '0;
    out_PC_pre  = '0;
    out_br_type = '0;
    if (out_valid) begin
      out_IR      = ir_q[head];
      out_PC      = pc_q[head];
      out_PC_pre  = pre_q[head];
      out_br_type = bt_q[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        pc_q[i]  <= '0;
        pre_q[i] <= '0;
        bt_q[i]  <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        ir_q[tail]  <= in_IR;
        pc_q[tail]  <= in_PC;
        pre_q[tail] <= in_PC_pre;
        bt_q[tail]  <= in_br_type;
        tail        <= tail + ADDR_W'(1);
      end
      if (deq)
        head <= head + ADDR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IBUF_EARLY_REDIRECT_EN

  typedef enum logic {NORMAL, SKIP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;
  logic        redir_q;
  logic        hit;
  logic        trig;

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = NORMAL;
    end else begin
      unique case (state)
        NORMAL: if (trig) state_nxt = SKIP;
        SKIP:   if (hit)  state_nxt = trig ? SKIP : NORMAL;
        default:          state_nxt = NORMAL;
      endcase
    end
  end

  // wrong-path packets are consumed but never enqueued while skipping
  always_comb begin
    drop = (state == SKIP) && in_valid && (in_PC != target);
    hit  = (state == SKIP) && in_valid && in_ready && (in_PC == target);
    trig = in_valid && in_ready && !flush && !drop
        && (in_br_type == 2'b10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q <= 1'b0;
      target  <= '0;
    end else begin
      redir_q <= trig;
      if (trig) target <= in_PC_pre;
    end
  end

  assign pre_redirect = !rst && redir_q;
  assign pre_target   = rst ? '0 : target;

`else

  assign drop         = 1'b0;
  assign pre_redirect = 1'b0;
  assign pre_target   = '0;

`endif

endmodule
